// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and constants for the serial magnitude comparator.
//   state_t       : controller states IDLE / RUN / DONE
//   RES_*         : one-hot {EQ, GT, LT} result encodings
//   cnt_w()       : chunk-counter width, never less than 1 bit
package cmp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [2:0] RES_EQ = 3'b100;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;
  function automatic int cnt_w(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction
endpackage

// File: rtl/serial_mag_comparator_chunk_compare.sv
// chunk_compare: combinational D-bit unsigned compare.
//   a, b : D-bit chunks
//   gt   : a > b
//   lt   : a < b   (equal when neither is set)
module chunk_compare #(
  parameter int D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  output logic         gt,
  output logic         lt
);
  assign gt = a > b;
  assign lt = a < b;
endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: MSB-first multi-cycle N-bit magnitude compare, D bits per cycle.
//   clk, rst     : clock, asynchronous active-high reset
//   start, SGN   : request a compare (sampled when not busy); 1 = two's-complement
//   A, B         : operands, captured with start
//   busy, done   : compare in progress; one-cycle result-valid pulse
//   EQ, GT, LT   : result flags, all 0 while busy
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int N = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         SGN,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         EQ,
  output logic         GT,
  output logic         LT
);
  if (D < 1 || D > N || N % D != 0) begin : g_param_err
    $error("serial_mag_comparator: need 1 <= D <= N and N %% D == 0");
  end
  localparam int CHUNKS = N / D;
  localparam int CW = cnt_w(CHUNKS);
  localparam logic [N-1:0] MSB = N'(1) << (N - 1);
  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] res_q, res_d;
  logic done_q, done_d;
  logic c_gt, c_lt;
  chunk_compare #(.D(D)) u_chunk (
    .a (a_q[N-1 -: D]),
    .b (b_q[N-1 -: D]),
    .gt(c_gt),
    .lt(c_lt)
  );
  // Signed mode flips the sign bits (offset binary) so the datapath stays unsigned.
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    res_d = res_q;
    done_d = 1'b0;
    if (state_q == RUN) begin
      if (c_gt || c_lt || cnt_q == '0) begin
        res_d = c_gt ? RES_GT : c_lt ? RES_LT : RES_EQ;
        done_d = 1'b1;
        state_d = DONE;
      end else begin
        a_d = a_q << D;
        b_d = b_q << D;
        cnt_d = cnt_q - 1'b1;
      end
    end else if (start) begin
      a_d = SGN ? A ^ MSB : A;
      b_d = SGN ? B ^ MSB : B;
      cnt_d = CW'(CHUNKS - 1);
      res_d = '0;
      state_d = RUN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign {EQ, GT, LT} = res_q;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator: table-driven and scoreboard check of serial_mag_comparator.
module tb_serial_mag_comparator;
  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [2:0]  flags;
    int          lat;
  } vec_t;
  typedef struct {
    logic [2:0] flags;
    int         t0;
    int         lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sgn = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic busy, done, eq, gt, lt;
  logic start8 = 1'b0;
  logic [7:0] a8a = '0, b8a = '0, a8b = '0, b8b = '0;
  logic busy8a, done8a, eq8a, gt8a, lt8a;
  logic busy8b, done8b, eq8b, gt8b, lt8b;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  exp_t sb[$];
  vec_t vecs[10];
  serial_mag_comparator #(.N(16), .D(4)) dut (
    .clk(clk), .rst(rst), .start(start), .SGN(sgn), .A(a), .B(b),
    .busy(busy), .done(done), .EQ(eq), .GT(gt), .LT(lt)
  );
  serial_mag_comparator #(.N(8), .D(8)) dut8a (
    .clk(clk), .rst(rst), .start(start8), .SGN(1'b0), .A(a8a), .B(b8a),
    .busy(busy8a), .done(done8a), .EQ(eq8a), .GT(gt8a), .LT(lt8a)
  );
  serial_mag_comparator #(.N(8), .D(1)) dut8b (
    .clk(clk), .rst(rst), .start(start8), .SGN(1'b0), .A(a8b), .B(b8b),
    .busy(busy8b), .done(done8b), .EQ(eq8b), .GT(gt8b), .LT(lt8b)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (busy) check("flags_zero_while_busy", {29'd0, eq, gt, lt}, 32'd0);
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("result_flags", {29'd0, eq, gt, lt}, {29'd0, e.flags});
        check("latency", cyc - e.t0, e.lat);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end
  task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                          input logic [2:0] f, input int lat, input bit push);
    exp_t e;
    a = va;
    b = vb;
    sgn = vs;
    start = 1'b1;
    e.flags = f;
    e.t0 = cyc + 1;
    e.lat = lat;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic wait_empty();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("done_timeout", sb.size(), 32'd0);
    sb.delete();
  endtask
  initial begin
    vecs[0] = '{16'h1234, 16'h1234, 1'b0, F_EQ, 4};
    vecs[1] = '{16'hA000, 16'h9FFF, 1'b0, F_GT, 1};
    vecs[2] = '{16'h1235, 16'h1234, 1'b0, F_GT, 4};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, F_LT, 1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, F_GT, 1};
    vecs[5] = '{16'hFFFF, 16'hFFFE, 1'b1, F_GT, 4};
    vecs[6] = '{16'h0001, 16'h0002, 1'b0, F_LT, 4};
    vecs[7] = '{16'h0000, 16'hFFFF, 1'b1, F_GT, 1};
    vecs[8] = '{16'h00F0, 16'h00E0, 1'b0, F_GT, 3};
    vecs[9] = '{16'h0012, 16'h0013, 1'b1, F_LT, 4};
    #2;
    check("reset_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].flags, vecs[i].lat, 1'b1);
      wait_empty();
      repeat (2) @(posedge clk);
      #1;
      check("flags_hold", {28'd0, done, eq, gt, lt}, {29'd0, vecs[i].flags});
    end
    start_op(16'h1235, 16'h1234, 1'b0, F_GT, 4, 1'b1);
    a = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_empty();
    start_op(16'h1234, 16'h1234, 1'b0, F_EQ, 4, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("no_done_after_abort", {31'd0, busy}, 32'd0);
    start_op(16'h4321, 16'h4321, 1'b0, F_EQ, 4, 1'b1);
    wait_empty();
    start_op(16'h5000, 16'h5000, 1'b0, F_EQ, 4, 1'b1);
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
    end
    check("first_done_seen", {31'd0, done}, 32'd1);
    start_op(16'h0001, 16'h0002, 1'b0, F_LT, 4, 1'b1);
    check("b2b_flags_cleared", {28'd0, done, eq, gt, lt}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_empty();
    repeat (10) @(posedge clk);
    #1;
    check("lt_holds", {27'd0, busy, done, eq, gt, lt}, {29'd0, F_LT});
    begin
      int t0, la, lb;
      la = -1;
      lb = -1;
      a8a = 8'h7F;
      b8a = 8'h80;
      a8b = 8'h01;
      b8b = 8'h00;
      start8 = 1'b1;
      t0 = cyc + 1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (done8a && la < 0) begin
          la = cyc - t0;
          check("n8d8_flags", {29'd0, eq8a, gt8a, lt8a}, {29'd0, F_LT});
        end
        if (done8b && lb < 0) begin
          lb = cyc - t0;
          check("n8d1_flags", {29'd0, eq8b, gt8b, lt8b}, {29'd0, F_GT});
        end
        @(posedge clk);
        #1;
      end
      check("n8d8_latency", la, 32'd1);
      check("n8d1_latency", lb, 32'd8);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
Multi-cycle, MSB-first magnitude comparator for N-bit operands.
- Evaluates D bits per clock.
- Exits early as soon as the result is decided.
- Supports unsigned and two's-complement modes, selected per operation.
- Successor to the team's purely combinational N-bit comparator, for wide operands where a single-cycle compare chain misses timing. Sits between operand registers and control logic behind a start/done handshake.

Parameters:
N, 16, operand width in bits; N >= 1.
D, 4, bits compared per cycle. Elaboration error unless 1 <= D <= N and N % D == 0.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a compare; sampled only when not busy
SGN  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
A  input  N  operand A; sampled with start
B  input  N  operand B; sampled with start
busy  output  1  high while a compare is in progress
done  output  1  one-cycle pulse when the result becomes valid
EQ  output  1  A == B
GT  output  1  A > B
LT  output  1  A < B

Behaviour:
- Reset (asynchronous, at any time including mid-compare):
  - state = IDLE.
  - busy, done, EQ, GT, LT = 0.
  - No done pulse is produced for an aborted compare.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start = 1 at edge t0:
  - Capture A and B into internal shift registers. If SGN = 1, invert the MSB of both operands on capture (offset-binary mapping), so the rest of the compare is unsigned.
  - Load chunk counter to CHUNKS-1, where CHUNKS = N/D.
  - Clear EQ, GT and LT to 0; set busy = 1; go to RUN.
- RUN, each cycle: compare the top D bits of both shift registers (chunk compare).
  - Chunk A > chunk B: at the next edge GT = 1, done = 1, busy = 0, go to DONE.
  - Chunk A < chunk B: same, with LT = 1.
  - Chunks equal, counter = 0: same, with EQ = 1.
  - Chunks equal, counter > 0: shift both registers left by D and decrement the counter.
- Latency: if the first differing chunk is chunk k (k = 0 is the MS chunk), done rises at edge t0 + k + 1. Equal operands take CHUNKS cycles; CHUNKS = 1 gives single-cycle latency.
- DONE:
  - EQ/GT/LT hold until the next accepted start or reset. Exactly one of them is high.
  - done is high only in the first cycle after the result is decided.
  - A start in the same cycle as the done pulse is accepted (back-to-back operation); the flags clear at the next edge.
- start while busy = 1 is ignored. Changes on A, B and SGN during RUN have no effect.
- While busy = 1, EQ, GT and LT all read 0.
- No X propagation: all registers are reset. The counter width is $clog2(CHUNKS) with a minimum of 1.

Decomposition:
- Package cmp_pkg contains:
  - state enum (IDLE, RUN, DONE);
  - result encoding constants (RES_EQ, RES_GT, RES_LT);
  - helper function for the counter width.
- Localparam CHUNKS is derived inside the module.
- One sub-module: chunk_compare, a combinational D-bit unsigned compare that outputs gt and lt; eq is the case where neither is set. Instantiated once on the top D bits.

Test Plan:
1. N=16, D=4, unsigned. A = 0x1234, B = 0x1234, start for 1 cycle -> busy for 4 cycles; done pulse at t0+4; EQ = 1, GT = 0, LT = 0.
2. Unsigned. A = 0xA000, B = 0x9FFF -> done at t0+1, GT = 1. A = 0x1235, B = 0x1234 -> done at t0+4, GT = 1. During RUN, drive A = 0 and pulse start -> result unchanged, no restart.
3. A = 0x8000, B = 0x0001: with SGN = 1 -> done at t0+1, LT = 1 (-32768 < 1); with SGN = 0 -> GT = 1. Also SGN = 1, A = 0xFFFF, B = 0xFFFE -> GT = 1 at t0+4.
4. Assert rst for one cycle at t0+2 of an equal-operand compare -> busy, done, EQ, GT, LT = 0 immediately (asynchronously); no done pulse follows; a new start then completes normally.
5. Back-to-back: pulse start in the done cycle with A = 0x0001, B = 0x0002 -> flags clear at the next edge; the second done pulse gives LT = 1. The flags hold indefinitely when no start follows.
6. Parameter sweep: with N=8, D=8, A = 0x7F, B = 0x80 unsigned -> single-cycle latency, LT = 1. With N=8, D=1, A = 0x01, B = 0x00 -> done at t0+8, GT = 1. With N=12, D=5 -> elaboration fails.
